// File: rtl/led_sequencer.sv
// led_sequencer: steps a WIDTH-bit colour code through MIN_CODE..MAX_CODE,
// wrapping in either direction. Hold mode advances every DIV cycles while the
// button is held. Step mode advances once per button press. All outputs are
// registered.
module led_sequencer #(
  parameter int WIDTH    = 3,
  parameter int MIN_CODE = 1,
  parameter int MAX_CODE = 6,
  parameter int DIV      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] colour,
  output logic             wrap
);

  // Prescaler is at least one bit wide, so DIV=1 still has a legal counter.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [WIDTH-1:0] MIN_C      = WIDTH'(MIN_CODE);
  localparam logic [WIDTH-1:0] MAX_C      = WIDTH'(MAX_CODE);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);

  // Reject parameter sets that have no legal colour range or no advance rate.
  generate
    if (WIDTH < 1 || MIN_CODE < 1 || MIN_CODE >= MAX_CODE ||
        longint'(MAX_CODE) > ((longint'(1) << WIDTH) - 1) || DIV < 1) begin : g_bad_params
      $error("led_sequencer: illegal parameters WIDTH=%0d MIN_CODE=%0d MAX_CODE=%0d DIV=%0d",
             WIDTH, MIN_CODE, MAX_CODE, DIV);
    end
  endgenerate

  logic [WIDTH-1:0] colour_q, colour_d;
  logic             wrap_q, wrap_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             button_q, button_d;

  logic             legal;
  logic             advance;
  logic             at_wrap;
  logic [WIDTH-1:0] target;

  // Next-state logic: recovery, advance target, hold/step advance decision.
  always_comb begin
    colour_d = colour_q;
    wrap_d   = 1'b0;
    presc_d  = presc_q;
    button_d = button;
    advance  = 1'b0;
    legal    = (colour_q >= MIN_C) && (colour_q <= MAX_C);

    if (dir) begin
      at_wrap = (colour_q == MIN_C);
      target  = at_wrap ? MAX_C : colour_q - 1'b1;
    end else begin
      at_wrap = (colour_q == MAX_C);
      target  = at_wrap ? MIN_C : colour_q + 1'b1;
    end

    if (!legal) begin
      // Out-of-range code (including 0 after reset) snaps to MIN_CODE.
      colour_d = MIN_C;
      presc_d  = '0;
    end else if (mode) begin
      // Step mode: rising edge of button only; prescaler parked at 0.
      presc_d = '0;
      advance = button && !button_q;
    end else if (button) begin
      if (presc_q == PRESC_LAST) begin
        advance = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d = '0;
    end

    if (advance) begin
      colour_d = target;
      wrap_d   = at_wrap;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      colour_q <= '0;
      wrap_q   <= 1'b0;
      presc_q  <= '0;
      button_q <= 1'b0;
    end else begin
      colour_q <= colour_d;
      wrap_q   <= wrap_d;
      presc_q  <= presc_d;
      button_q <= button_d;
    end
  end

  assign colour = colour_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed testbench for led_sequencer: four parameterisations share one
// stimulus bus; each scenario resets and then checks the instance it targets.
module tb_led_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button = 1'b0;
  logic mode = 1'b0;
  logic dir = 1'b0;

  logic [2:0] col_a, col_b;
  logic [3:0] col_c;
  logic [1:0] col_e;
  logic       wrap_a, wrap_b, wrap_c, wrap_e;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_sequencer #(.WIDTH(3), .MIN_CODE(1), .MAX_CODE(6), .DIV(1)) u_a (
    .clk(clk), .rst(rst), .button(button), .mode(mode), .dir(dir), .colour(col_a), .wrap(wrap_a));
  led_sequencer #(.WIDTH(3), .MIN_CODE(1), .MAX_CODE(6), .DIV(4)) u_b (
    .clk(clk), .rst(rst), .button(button), .mode(mode), .dir(dir), .colour(col_b), .wrap(wrap_b));
  led_sequencer #(.WIDTH(4), .MIN_CODE(3), .MAX_CODE(12), .DIV(1)) u_c (
    .clk(clk), .rst(rst), .button(button), .mode(mode), .dir(dir), .colour(col_c), .wrap(wrap_c));
  led_sequencer #(.WIDTH(2), .MIN_CODE(1), .MAX_CODE(2), .DIV(1)) u_e (
    .clk(clk), .rst(rst), .button(button), .mode(mode), .dir(dir), .colour(col_e), .wrap(wrap_e));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset every instance, then one edge of recovery to MIN_CODE.
  task automatic do_reset();
    rst = 1'b1;
    button = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; button = 1'b0; mode = 1'b0; dir = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (col_a !== 3'd0 || wrap_a !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got colour=%0d wrap=%b want colour=0 wrap=0", k, col_a, wrap_a);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (col_a !== 3'd1 || wrap_a !== 1'b0) begin
        bad++;
        $display("FAIL reset_recover cyc=%0d got colour=%0d wrap=%b want colour=1 wrap=0", k, col_a, wrap_a);
      end
    end
  endtask

  task automatic test_hold_legacy();
    int exp_c[7] = '{2, 3, 4, 5, 6, 1, 2};
    bit exp_w[7] = '{0, 0, 0, 0, 0, 1, 0};
    button = 1'b1; mode = 1'b0; dir = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      total++;
      if (col_a !== 3'(exp_c[k]) || wrap_a !== exp_w[k]) begin
        bad++;
        $display("FAIL hold_legacy edge=%0d got colour=%0d wrap=%b want colour=%0d wrap=%b",
                 k + 1, col_a, wrap_a, exp_c[k], exp_w[k]);
      end
    end
    button = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (col_a !== 3'd2 || wrap_a !== 1'b0) begin
        bad++;
        $display("FAIL hold_release cyc=%0d got colour=%0d wrap=%b want colour=2 wrap=0", k, col_a, wrap_a);
      end
    end
  endtask

  task automatic test_rate_div();
    int want;
    mode = 1'b0; dir = 1'b0;
    do_reset();
    button = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      want = 1 + k / 4;
      total++;
      if (col_b !== 3'(want) || wrap_b !== 1'b0) begin
        bad++;
        $display("FAIL rate_div edge=%0d got colour=%0d wrap=%b want colour=%0d wrap=0", k, col_b, wrap_b, want);
      end
    end
    // Six more held edges: advance to 5 at edge 4, prescaler at 2 after edge 6.
    for (int k = 1; k <= 6; k++) begin
      tick();
      want = (k < 4) ? 4 : 5;
      total++;
      if (col_b !== 3'(want)) begin
        bad++;
        $display("FAIL rate_prehold edge=%0d got colour=%0d want colour=%0d", k, col_b, want);
      end
    end
    button = 1'b0;
    tick();
    button = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      want = (k < 4) ? 5 : 6;
      total++;
      if (col_b !== 3'(want)) begin
        bad++;
        $display("FAIL rate_rehold edge=%0d got colour=%0d want colour=%0d", k, col_b, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    int want;
    // From colour=6, prescaler=0: count down to 5, then 2 more held edges.
    dir = 1'b1; button = 1'b1; mode = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    total++;
    if (col_b !== 3'd5) begin
      bad++;
      $display("FAIL mid_setup got colour=%0d want colour=5", col_b);
    end
    rst = 1'b1;
    tick();
    total++;
    if (col_b !== 3'd0 || wrap_b !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got colour=%0d wrap=%b want colour=0 wrap=0", col_b, wrap_b);
    end
    rst = 1'b0; dir = 1'b0;
    tick();
    total++;
    if (col_b !== 3'd1) begin
      bad++;
      $display("FAIL mid_recover got colour=%0d want colour=1", col_b);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      want = (k < 4) ? 1 : 2;
      total++;
      if (col_b !== 3'(want) || wrap_b !== 1'b0) begin
        bad++;
        $display("FAIL mid_first_adv edge=%0d got colour=%0d wrap=%b want colour=%0d wrap=0",
                 k, col_b, wrap_b, want);
      end
    end
  endtask

  task automatic test_mode_switch();
    int want;
    // colour=2, prescaler=0, button held.
    tick(); tick();
    mode = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (col_b !== 3'd2) begin
        bad++;
        $display("FAIL switch_no_adv cyc=%0d got colour=%0d want colour=2", k, col_b);
      end
    end
    mode = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      want = (k < 4) ? 2 : 3;
      total++;
      if (col_b !== 3'(want)) begin
        bad++;
        $display("FAIL switch_restart edge=%0d got colour=%0d want colour=%0d", k, col_b, want);
      end
    end
  endtask

  task automatic test_step();
    int  exp_c[8] = '{6, 6, 6, 6, 6, 6, 5, 5};
    bit  exp_w[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    bit  btn[8]   = '{1, 1, 1, 1, 1, 0, 1, 0};
    mode = 1'b0; dir = 1'b0;
    do_reset();
    mode = 1'b1; dir = 1'b1;
    for (int k = 0; k < 8; k++) begin
      button = btn[k];
      tick();
      total++;
      if (col_a !== 3'(exp_c[k]) || wrap_a !== exp_w[k]) begin
        bad++;
        $display("FAIL step edge=%0d got colour=%0d wrap=%b want colour=%0d wrap=%b",
                 k + 1, col_a, wrap_a, exp_c[k], exp_w[k]);
      end
    end
  endtask

  task automatic test_boundaries();
    int  exp_c[4] = '{12, 3, 12, 11};
    bit  exp_w[4] = '{0, 1, 1, 0};
    bit  dirs[4]  = '{0, 0, 1, 1};
    mode = 1'b0; dir = 1'b0;
    do_reset();
    button = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (col_c !== 4'(3 + k)) begin
        bad++;
        $display("FAIL bound_climb edge=%0d got colour=%0d want colour=%0d", k, col_c, 3 + k);
      end
    end
    for (int k = 0; k < 4; k++) begin
      dir = dirs[k];
      tick();
      total++;
      if (col_c !== 4'(exp_c[k]) || wrap_c !== exp_w[k]) begin
        bad++;
        $display("FAIL bound_wrap step=%0d got colour=%0d wrap=%b want colour=%0d wrap=%b",
                 k, col_c, wrap_c, exp_c[k], exp_w[k]);
      end
    end
    button = 1'b0;
    force u_c.colour_q = 4'd15;
    #1;
    release u_c.colour_q;
    tick();
    total++;
    if (col_c !== 4'd3 || wrap_c !== 1'b0) begin
      bad++;
      $display("FAIL bound_illegal got colour=%0d wrap=%b want colour=3 wrap=0", col_c, wrap_c);
    end
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; dir = 1'b0;
    do_reset();
    button = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (col_e !== ((k % 2 == 0) ? 2'd2 : 2'd1) || wrap_e !== ((k % 2 == 0) ? 1'b0 : 1'b1)) begin
        bad++;
        $display("FAIL back_to_back edge=%0d got colour=%0d wrap=%b want colour=%0d wrap=%0d",
                 k + 1, col_e, wrap_e, (k % 2 == 0) ? 2 : 1, k % 2);
      end
    end
    button = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold_legacy();
    test_rate_div();
    test_reset_mid();
    test_mode_switch();
    test_step();
    test_boundaries();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
